hit_event_scheduler: RTL and testbench

// - Shares the single per-frame score-increment port of the game-state block among N_ENEMY enemy sprites.
// - Queues hit events, grants one per frame round-robin, and emits a registered hit pulse with the enemy id.
// - Owns the player lives counter, the post-collision invulnerability window and game_over generation.
// - Sits between the enemy/missile collision logic and the game-state FSM.

---
 rtl/hit_event_scheduler_pkg.sv | 14 +
 rtl/hit_event_scheduler_if.sv | 28 ++
 rtl/hit_event_scheduler_rr_arbiter.sv | 24 ++
 rtl/hit_event_scheduler.sv | 119 +++++++++++
 tb/tb_hit_event_scheduler.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/hit_event_scheduler_pkg.sv
// Shared types and defaults for the hit event scheduler and the game-state block.
package hit_event_scheduler_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, INVULN, DEAD} sched_state_t;

    localparam int N_ENEMY_DEF       = 8;
    localparam int LIVES_INIT_DEF    = 3;
    localparam int INVULN_FRAMES_DEF = 60;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/hit_event_scheduler_if.sv
// Bundle between collision logic / game-state FSM (master) and the scheduler (slave).
interface hit_event_scheduler_if #(
    parameter int N_ENEMY = 8,
    parameter int LIVES_W = 2
);
    localparam int IW = hit_event_scheduler_pkg::clog2_min1(N_ENEMY);

    logic               enable;
    logic [N_ENEMY-1:0] enemy_hit;
    logic               player_collide;
    logic               hit;
    logic [IW-1:0]      hit_id;
    logic [LIVES_W-1:0] lives;
    logic               invuln;
    logic               game_over;
    logic               dropped;

    modport master (
        output enable, enemy_hit, player_collide,
        input  hit, hit_id, lives, invuln, game_over, dropped
    );

    modport slave (
        input  enable, enemy_hit, player_collide,
        output hit, hit_id, lives, invuln, game_over, dropped
    );

endinterface

// File: rtl/hit_event_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after ptr, wrapping.
module rr_arbiter import hit_event_scheduler_pkg::*; #(
    parameter int N  = 8,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    // Scan from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[IW'((int'(ptr) + k) % N)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/hit_event_scheduler.sv
// Per-frame hit arbitration onto the single score port, plus lives / invulnerability / game-over.
module hit_event_scheduler import hit_event_scheduler_pkg::*; #(
    parameter int N_ENEMY       = N_ENEMY_DEF,
    parameter int PEND_W        = 2,
    parameter int LIVES_INIT    = LIVES_INIT_DEF,
    parameter int LIVES_W       = 2,
    parameter int INVULN_FRAMES = INVULN_FRAMES_DEF
) (
    input logic                    frame_clk,
    input logic                    Reset_n,
    hit_event_scheduler_if.slave   bus
);

    localparam int IW = clog2_min1(N_ENEMY);
    localparam int TW = clog2_min1(INVULN_FRAMES);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    sched_state_t                     state;
    logic [N_ENEMY-1:0][PEND_W-1:0]   pending, pend_nxt;
    logic [IW-1:0]                    rr_ptr;
    logic [TW-1:0]                    timer;
    logic [LIVES_W-1:0]               lives;
    logic                             hit, invuln, game_over, dropped;
    logic [IW-1:0]                    hit_id;
    logic                             active, gnt_valid;
    logic [IW-1:0]                    gnt_idx;
    logic [N_ENEMY-1:0]               req, gnt_oh, sat;

    assign active = bus.enable && (state == PLAY || state == INVULN);

    // A hit arriving this frame is a candidate immediately, even with nothing queued.
    for (genvar i = 0; i < N_ENEMY; i++) begin : g_lane
        assign req[i]    = active && (pending[i] != '0 || bus.enemy_hit[i]);
        assign gnt_oh[i] = gnt_valid && (gnt_idx == IW'(i));
        assign sat[i]    = active && bus.enemy_hit[i] && !gnt_oh[i] && (pending[i] == PEND_MAX);
    end

    rr_arbiter #(.N(N_ENEMY), .IW(IW)) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        pend_nxt = pending;
        for (int i = 0; i < N_ENEMY; i++) begin
            if (!bus.enable || state == IDLE)
                pend_nxt[i] = '0;
            else if (active && !sat[i])
                pend_nxt[i] = pending[i] + PEND_W'(bus.enemy_hit[i]) - PEND_W'(gnt_oh[i]);
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            pending   <= '0;
            rr_ptr    <= '0;
            timer     <= '0;
            lives     <= LIVES_W'(LIVES_INIT);
            hit       <= 1'b0;
            hit_id    <= '0;
            invuln    <= 1'b0;
            game_over <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            pending <= pend_nxt;
            hit     <= gnt_valid;
            dropped <= |sat;
            if (gnt_valid) begin
                hit_id <= gnt_idx;
                rr_ptr <= (gnt_idx == IW'(N_ENEMY - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (!bus.enable) begin
                state     <= IDLE;
                lives     <= LIVES_W'(LIVES_INIT);
                timer     <= '0;
                invuln    <= 1'b0;
                game_over <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= PLAY;
                        lives <= LIVES_W'(LIVES_INIT);
                    end
                    PLAY: if (bus.player_collide) begin
                        if (lives == LIVES_W'(1)) begin
                            state     <= DEAD;
                            lives     <= '0;
                            game_over <= 1'b1;
                        end else begin
                            state  <= INVULN;
                            lives  <= lives - 1'b1;
                            timer  <= TW'(INVULN_FRAMES - 1);
                            invuln <= 1'b1;
                        end
                    end
                    INVULN: if (timer == '0) begin
                        state  <= PLAY;
                        invuln <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                    DEAD: game_over <= 1'b1;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.hit       = hit;
    assign bus.hit_id    = hit_id;
    assign bus.lives     = lives;
    assign bus.invuln    = invuln;
    assign bus.game_over = game_over;
    assign bus.dropped   = dropped;

endmodule

// File: tb/tb_hit_event_scheduler.sv
// Scoreboard bench: frame-level reference model pushes expectations, a monitor pops and compares.
module tb_hit_event_scheduler;

    localparam int N    = 8;
    localparam int PMAX = 3;
    localparam int LINIT = 3;
    localparam int INV  = 60;
    localparam int M_IDLE = 0, M_PLAY = 1, M_INV = 2, M_DEAD = 3;

    logic frame_clk = 1'b0;
    logic Reset_n;

    hit_event_scheduler_if #(.N_ENEMY(N), .LIVES_W(2)) bus();

    hit_event_scheduler #(
        .N_ENEMY(N), .PEND_W(2), .LIVES_INIT(LINIT), .LIVES_W(2), .INVULN_FRAMES(INV)
    ) dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        bit hit;
        int id;
        int lives;
        bit inv;
        bit go;
        bit drop;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one step per frame, from the game rules.
    initial begin : model
        int ms, mlives, mtimer, mptr, g, j;
        int pend[N];
        bit d;
        exp_t e;
        ms = M_IDLE; mlives = LINIT; mtimer = 0; mptr = 0;
        for (int i = 0; i < N; i++) pend[i] = 0;
        forever begin
            @(posedge frame_clk or negedge Reset_n);
            if (!Reset_n) begin
                ms = M_IDLE; mlives = LINIT; mtimer = 0; mptr = 0;
                for (int i = 0; i < N; i++) pend[i] = 0;
                q.delete();
            end else begin
                g = -1;
                d = 1'b0;
                if (bus.enable && (ms == M_PLAY || ms == M_INV)) begin
                    for (int k = 0; k < N; k++) begin
                        j = (mptr + k) % N;
                        if (g < 0 && (pend[j] > 0 || bus.enemy_hit[j])) g = j;
                    end
                    for (int i = 0; i < N; i++) begin
                        if (bus.enemy_hit[i] && i != g && pend[i] == PMAX) d = 1'b1;
                        else begin
                            if (bus.enemy_hit[i]) pend[i]++;
                            if (i == g) pend[i]--;
                        end
                    end
                    if (g >= 0) mptr = (g + 1) % N;
                end
                if (!bus.enable) begin
                    ms = M_IDLE; mlives = LINIT; mtimer = 0;
                    for (int i = 0; i < N; i++) pend[i] = 0;
                end else if (ms == M_IDLE) begin
                    ms = M_PLAY; mlives = LINIT;
                end else if (ms == M_PLAY && bus.player_collide) begin
                    if (mlives == 1) begin
                        ms = M_DEAD; mlives = 0;
                    end else begin
                        ms = M_INV; mlives--; mtimer = INV - 1;
                    end
                end else if (ms == M_INV) begin
                    if (mtimer == 0) ms = M_PLAY;
                    else mtimer--;
                end
                e.hit = (g >= 0); e.id = g; e.lives = mlives;
                e.inv = (ms == M_INV); e.go = (ms == M_DEAD); e.drop = d;
                q.push_back(e);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge frame_clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("hit", int'(bus.hit), int'(e.hit));
                if (e.hit) chk("hit_id", int'(bus.hit_id), e.id);
                chk("lives", int'(bus.lives), e.lives);
                chk("invuln", int'(bus.invuln), int'(e.inv));
                chk("game_over", int'(bus.game_over), int'(e.go));
                chk("dropped", int'(bus.dropped), int'(e.drop));
            end
        end
    end

    task automatic frame(input bit en, input logic [N-1:0] eh, input bit col);
        @(negedge frame_clk);
        bus.enable         = en;
        bus.enemy_hit      = eh;
        bus.player_collide = col;
    endtask

    initial begin : stim
        logic [N-1:0] r;
        Reset_n = 1'b0;
        bus.enable = 1'b0; bus.enemy_hit = '0; bus.player_collide = 1'b0;
        repeat (2) @(negedge frame_clk);
        Reset_n = 1'b1;

        // two simultaneous hits drain over two frames
        frame(1, '0, 0);
        frame(1, 8'h05, 0);
        repeat (3) frame(1, '0, 0);
        // one enemy hitting every frame never queues
        repeat (5) frame(1, 8'h20, 0);
        repeat (2) frame(1, '0, 0);
        // pointer lands on 3, then 1/4/7 together
        frame(1, 8'h04, 0);
        frame(1, 8'h92, 0);
        repeat (4) frame(1, '0, 0);
        // collision, ignored second collision, invulnerability expiry
        frame(1, '0, 1);
        repeat (9) frame(1, '0, 0);
        frame(1, 8'h11, 1);
        repeat (55) frame(1, '0, 0);
        // second collision then fatal one with hits in flight
        frame(1, '0, 1);
        repeat (62) frame(1, '0, 0);
        frame(1, 8'hC3, 1);
        repeat (3) frame(1, 8'hFF, 0);
        frame(0, 8'hFF, 0);
        repeat (2) frame(1, '0, 0);
        // saturation then asynchronous reset mid-play
        repeat (6) frame(1, 8'hFF, 0);
        @(negedge frame_clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_hit", int'(bus.hit), 0);
        chk("rst_hit_id", int'(bus.hit_id), 0);
        chk("rst_lives", int'(bus.lives), LINIT);
        chk("rst_invuln", int'(bus.invuln), 0);
        chk("rst_game_over", int'(bus.game_over), 0);
        chk("rst_dropped", int'(bus.dropped), 0);
        bus.enemy_hit = '0; bus.enable = 1'b1;
        @(negedge frame_clk);
        Reset_n = 1'b1;
        repeat (6) frame(1, '0, 0);

        // randomized play: alternating dense and sparse hit phases
        for (int f = 0; f < 3000; f++) begin
            if (((f / 300) % 2) == 1) r = N'($urandom);
            else if ($urandom_range(0, 3) == 0) r = N'(1) << $urandom_range(0, N - 1);
            else r = '0;
            frame($urandom_range(0, 299) != 0, r, $urandom_range(0, 49) == 0);
        end
        repeat (3) frame(1, '0, 0);
        @(negedge frame_clk);
        #1;
        chk("sb_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
